// File: rtl/lbp_hist_if.sv
// lbp_hist_if: bundle between the LBP engine / drain consumer and the histogram block.
//   lbp_valid/lbp_addr/lbp_data/finish : code stream from the LBP engine
//   hist_valid/hist_ready/hist_addr/hist_data : bin drain handshake
//   pix_cnt/late_err/done : status
interface lbp_hist_if #(
    parameter int ADDR_W = 14,
    parameter int BIN_W  = 15
);
    logic              lbp_valid;
    logic [ADDR_W-1:0] lbp_addr;
    logic [7:0]        lbp_data;
    logic              finish;
    logic              hist_valid;
    logic              hist_ready;
    logic [7:0]        hist_addr;
    logic [BIN_W-1:0]  hist_data;
    logic [ADDR_W:0]   pix_cnt;
    logic              late_err;
    logic              done;
    modport master (
        output lbp_valid, lbp_addr, lbp_data, finish, hist_ready,
        input  hist_valid, hist_addr, hist_data, pix_cnt, late_err, done
    );
    modport slave (
        input  lbp_valid, lbp_addr, lbp_data, finish, hist_ready,
        output hist_valid, hist_addr, hist_data, pix_cnt, late_err, done
    );
endinterface

// File: rtl/lbp_hist.sv
// lbp_hist: 256-bin LBP code histogram, accumulated at one code per cycle, then drained bin by bin.
//   i_clk   : system clock, rising edge
//   i_reset : synchronous active-high reset
//   bus     : lbp_hist_if slave (code stream in, bin drain out, status out)
module lbp_hist #(
    parameter int IMG_W       = 128,
    parameter int ADDR_W      = 14,
    parameter int BIN_W       = 15,
    parameter bit SKIP_BORDER = 1'b1
) (
    input logic i_clk,
    input logic i_reset,
    lbp_hist_if.slave bus
);
    typedef enum logic [1:0] {ACCUM, FLUSH, DRAIN, DONE} state_t;
    state_t            r_state, w_state_nx;
    logic [BIN_W-1:0]  r_bin [256];
    logic              r_s1_v, r_s2_v;
    logic [7:0]        r_s1_code, r_s2_code;
    logic [BIN_W-1:0]  r_s2_val;
    logic              r_hist_valid;
    logic [7:0]        r_hist_addr;
    logic [ADDR_W:0]   r_pix_cnt;
    logic              r_late_err;
    logic [ADDR_W-1:0] w_row, w_col;
    logic              w_border, w_take, w_acc;
    logic [BIN_W-1:0]  w_rd, w_inc;

    assign w_row    = bus.lbp_addr / ADDR_W'(IMG_W);
    assign w_col    = bus.lbp_addr % ADDR_W'(IMG_W);
    assign w_border = (w_row == '0) || (w_row == ADDR_W'(IMG_W - 1)) ||
                      (w_col == '0) || (w_col == ADDR_W'(IMG_W - 1));
    assign w_take   = bus.lbp_valid && (r_state == ACCUM) && !(SKIP_BORDER && w_border);
    assign w_acc    = r_hist_valid && bus.hist_ready;
    // S2 has not written its bin yet, so a same-bin S1 must take S2's value
    assign w_rd     = (r_s2_v && r_s2_code == r_s1_code) ? r_s2_val : r_bin[r_s1_code];
    assign w_inc    = (&w_rd) ? w_rd : w_rd + BIN_W'(1);

    always_comb begin
        w_state_nx = r_state;
        case (r_state)
            ACCUM:   w_state_nx = bus.finish ? FLUSH : ACCUM;
            FLUSH:   w_state_nx = DRAIN;
            DRAIN:   w_state_nx = (w_acc && r_hist_addr == 8'hFF) ? DONE : DRAIN;
            default: w_state_nx = DONE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state      <= ACCUM;
            r_s1_v       <= 1'b0;
            r_s1_code    <= '0;
            r_s2_v       <= 1'b0;
            r_s2_code    <= '0;
            r_s2_val     <= '0;
            r_hist_valid <= 1'b0;
            r_hist_addr  <= '0;
            r_pix_cnt    <= '0;
            r_late_err   <= 1'b0;
            for (int i = 0; i < 256; i++) r_bin[i] <= '0;
        end else begin
            r_state   <= w_state_nx;
            r_s1_v    <= w_take;
            r_s1_code <= bus.lbp_data;
            r_s2_v    <= r_s1_v;
            r_s2_code <= r_s1_code;
            r_s2_val  <= w_inc;
            if (r_s2_v) r_bin[r_s2_code] <= r_s2_val;
            if (w_take && !(&r_pix_cnt)) r_pix_cnt <= r_pix_cnt + (ADDR_W+1)'(1);
            if (bus.lbp_valid && r_state != ACCUM) r_late_err <= 1'b1;
            // first DRAIN cycle lets S2's final write land before bin 0 is shown
            if (r_state == DRAIN) begin
                if (w_acc) begin
                    r_hist_addr <= r_hist_addr + 8'd1;
                    if (r_hist_addr == 8'hFF) r_hist_valid <= 1'b0;
                end else begin
                    r_hist_valid <= 1'b1;
                end
            end
        end
    end

    assign bus.hist_valid = r_hist_valid;
    assign bus.hist_addr  = r_hist_addr;
    assign bus.hist_data  = r_hist_valid ? r_bin[r_hist_addr] : '0;
    assign bus.pix_cnt    = r_pix_cnt;
    assign bus.late_err   = r_late_err;
    assign bus.done       = (r_state == DONE);
endmodule

// File: tb/tb_lbp_hist.sv
// tb_lbp_hist: randomized and directed bench for lbp_hist against a behavioural histogram model.
module tb_lbp_hist;
    logic        clk = 1'b0;
    logic        t_reset = 1'b1, t_valid = 1'b0, t_finish = 1'b0, t_ready = 1'b0;
    logic [13:0] t_addr = '0;
    logic [7:0]  t_data = '0;
    int          n_checks = 0, n_fail = 0;
    int          rx [2][256];
    int          m_bin [2][256];
    int          m_pix [2];
    int          m_since, m_addr;
    bit          m_valid, m_done, m_late, m_init = 1'b0;
    localparam int SAT = 32767;

    always #5 clk = ~clk;

    lbp_hist_if #(.ADDR_W(14), .BIN_W(15)) if0 ();
    lbp_hist_if #(.ADDR_W(14), .BIN_W(15)) if1 ();
    assign if0.lbp_valid = t_valid;  assign if1.lbp_valid = t_valid;
    assign if0.lbp_addr  = t_addr;   assign if1.lbp_addr  = t_addr;
    assign if0.lbp_data  = t_data;   assign if1.lbp_data  = t_data;
    assign if0.finish    = t_finish; assign if1.finish    = t_finish;
    assign if0.hist_ready = t_ready; assign if1.hist_ready = t_ready;

    lbp_hist #(.IMG_W(128), .ADDR_W(14), .BIN_W(15), .SKIP_BORDER(1'b1)) dut0 (.i_clk(clk), .i_reset(t_reset), .bus(if0));
    lbp_hist #(.IMG_W(128), .ADDR_W(14), .BIN_W(15), .SKIP_BORDER(1'b0)) dut1 (.i_clk(clk), .i_reset(t_reset), .bus(if1));

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic bit is_border(input int a);
        int r, c;
        r = a / 128;
        c = a % 128;
        return r == 0 || r == 127 || c == 0 || c == 127;
    endfunction

    // Model: a code counts while still accumulating; drain starts two edges after finish is seen.
    always @(posedge clk) begin
        if (t_reset) begin
            for (int k = 0; k < 2; k++) begin
                m_pix[k] = 0;
                for (int i = 0; i < 256; i++) m_bin[k][i] = 0;
            end
            m_since = -1; m_addr = 0; m_valid = 0; m_done = 0; m_late = 0; m_init = 1;
        end else if (m_init) begin
            if (m_since < 0) begin
                if (t_valid)
                    for (int k = 0; k < 2; k++)
                        if (k == 1 || !is_border(int'(t_addr))) begin
                            if (m_bin[k][t_data] < SAT) m_bin[k][t_data]++;
                            if (m_pix[k] < SAT) m_pix[k]++;
                        end
                if (t_finish) m_since = 0;
            end else begin
                if (t_valid) m_late = 1;
                if (m_valid && t_ready) begin
                    m_addr++;
                    if (m_addr == 256) m_done = 1;
                end
                if (m_since < 2) m_since++;
                m_valid = !m_done && m_since >= 2;
            end
        end
    end

    task automatic cmp_inst(input int k, input logic hv, input logic [7:0] ha, input logic [14:0] hd,
                            input logic [14:0] pc, input logic le, input logic dn);
        chk($sformatf("d%0d_hist_valid", k), int'(hv), int'(m_valid));
        chk($sformatf("d%0d_done", k), int'(dn), int'(m_done));
        chk($sformatf("d%0d_late_err", k), int'(le), int'(m_late));
        chk($sformatf("d%0d_pix_cnt", k), int'(pc), m_pix[k]);
        if (m_valid) begin
            chk($sformatf("d%0d_hist_addr", k), int'(ha), m_addr);
            chk($sformatf("d%0d_hist_data", k), int'(hd), m_bin[k][m_addr]);
        end
        if (hv && t_ready) rx[k][ha] = int'(hd);
    endtask

    always @(negedge clk) begin
        if (m_init) begin
            cmp_inst(0, if0.hist_valid, if0.hist_addr, if0.hist_data, if0.pix_cnt, if0.late_err, if0.done);
            cmp_inst(1, if1.hist_valid, if1.hist_addr, if1.hist_data, if1.pix_cnt, if1.late_err, if1.done);
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_rx();
        for (int k = 0; k < 2; k++)
            for (int i = 0; i < 256; i++) rx[k][i] = -1;
    endtask

    task automatic do_reset();
        t_finish = 0; t_valid = 0; t_ready = 0; t_reset = 1;
        cyc();
        t_reset = 0;
    endtask

    task automatic rand_stream(input int n);
        for (int i = 0; i < n; i++) begin
            t_valid = ($urandom_range(0, 3) != 0);
            t_addr  = 14'($urandom_range(0, 16383));
            t_data  = 8'($urandom_range(0, 3)) | (($urandom_range(0, 1) != 0) ? 8'hFC : 8'h00);
            cyc();
        end
        t_valid = 0;
    endtask

    // mode 0: always ready, 1: random ready, 2: stall at bin 7 and inject a late code
    task automatic drain(input int mode, output int cv);
        int budget;
        bit stalled, pulsed;
        budget = 3000; stalled = 0; pulsed = 0; cv = 0;
        while (!if0.done && budget > 0) begin
            t_valid = 0;
            if (mode == 2 && !stalled && if0.hist_valid && if0.hist_addr == 8'd7) begin
                stalled = 1;
                t_ready = 0;
                for (int s = 0; s < 3; s++) begin
                    cyc();
                    chk("stall_addr", int'(if0.hist_addr), 7);
                    chk("stall_valid", int'(if0.hist_valid), 1);
                end
                t_ready = 1;
                cyc();
                chk("after_stall_addr", int'(if0.hist_addr), 8);
                budget -= 4;
                continue;
            end
            if (mode == 2 && !pulsed && if0.hist_valid && if0.hist_addr == 8'd20) begin
                pulsed = 1; t_valid = 1; t_addr = 14'd129; t_data = 8'h5A;
            end
            t_ready = (mode == 1) ? 1'($urandom_range(0, 1)) : 1'b1;
            if (if0.hist_valid) cv++;
            cyc();
            budget--;
        end
        t_valid = 0;
        if (budget <= 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL drain_timeout: got done=%0d, expected done=1", if0.done);
        end
    endtask

    initial begin
        int cv, nz;
        logic [13:0] al [16];
        logic [7:0]  dl [16];
        cyc(); cyc();
        chk("rst_hist_valid", int'(if0.hist_valid), 0);
        chk("rst_hist_addr", int'(if0.hist_addr), 0);
        chk("rst_hist_data", int'(if0.hist_data), 0);
        chk("rst_pix_cnt", int'(if0.pix_cnt), 0);
        chk("rst_late_err", int'(if0.late_err), 0);
        chk("rst_done", int'(if0.done), 0);
        t_reset = 0;

        for (int a = 0; a < 16384; a++) begin
            t_valid = 1; t_addr = 14'(a); t_data = 8'h00;
            cyc();
        end
        t_valid = 0; t_finish = 1;
        cyc();
        clear_rx();
        drain(0, cv);
        chk("t1_bin0", rx[0][0], 15876);
        chk("t1_bin0_noskip", rx[1][0], 16384);
        nz = 0;
        for (int i = 1; i < 256; i++) nz += int'(rx[0][i] != 0) + int'(rx[1][i] != 0);
        chk("t1_other_bins", nz, 0);
        chk("t1_pix", int'(if0.pix_cnt), 15876);
        chk("t1_pix_noskip", int'(if1.pix_cnt), 16384);
        chk("t1_valid_cycles", cv, 256);
        chk("t1_done", int'(if0.done), 1);
        cyc(); cyc();
        chk("t1_done_hold", int'(if0.done), 1);

        do_reset();
        for (int i = 0; i < 4; i++) begin al[i] = 14'(129 + i); dl[i] = 8'h5A; end
        for (int i = 0; i < 5; i++) begin al[4+i] = 14'(200 + i); dl[4+i] = (i % 2 == 0) ? 8'h11 : 8'h22; end
        al[9] = 14'd0; al[10] = 14'd127; al[11] = 14'd128; al[12] = 14'd255;
        al[13] = 14'd16256; al[14] = 14'd16383; al[15] = 14'd129;
        for (int i = 9; i < 16; i++) dl[i] = 8'hFF;
        for (int i = 0; i < 16; i++) begin
            t_valid = 1; t_addr = al[i]; t_data = dl[i]; t_finish = (i == 15);
            cyc();
        end
        t_valid = 0;
        clear_rx();
        drain(2, cv);
        chk("t2_bin5a", rx[0][8'h5A], 4);
        chk("t2_bin11", rx[0][8'h11], 3);
        chk("t2_bin22", rx[0][8'h22], 2);
        chk("t2_binff", rx[0][8'hFF], 1);
        chk("t2_binff_noskip", rx[1][8'hFF], 7);
        chk("t2_pix", int'(if0.pix_cnt), 10);
        chk("t2_pix_noskip", int'(if1.pix_cnt), 16);
        chk("t2_late_err", int'(if0.late_err), 1);
        chk("t2_done", int'(if0.done), 1);

        do_reset();
        rand_stream(3000);
        t_finish = 1;
        cyc();
        clear_rx();
        drain(1, cv);
        chk("rnd_done", int'(if0.done && if1.done), 1);

        do_reset();
        rand_stream(500);
        t_finish = 1;
        t_ready = 1;
        cv = 1000;
        while (!(if0.hist_valid && if0.hist_addr == 8'd100) && cv > 0) begin
            cyc();
            cv--;
        end
        chk("mid_reach_100", int'(cv > 0), 1);
        t_reset = 1;
        cyc();
        chk("mid_rst_valid", int'(if0.hist_valid), 0);
        chk("mid_rst_done", int'(if0.done), 0);
        chk("mid_rst_pix", int'(if0.pix_cnt), 0);
        t_reset = 0;
        clear_rx();
        drain(0, cv);
        nz = 0;
        for (int i = 0; i < 256; i++) nz += int'(rx[0][i] != 0) + int'(rx[1][i] != 0);
        chk("redrain_zero", nz, 0);
        chk("redrain_cycles", cv, 256);
        chk("redrain_done", int'(if0.done), 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
